// File: rtl/kianv_regfile_pkg.sv
// kianv_regfile_pkg: shared state encoding and register-number constants for register_file_mp
package kianv_regfile_pkg;
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    localparam int REG_X0 = 0;
    localparam int REG_SP = 2;
    localparam int DEPTH_RV32I = 32;
    localparam int DEPTH_RV32E = 16;
endpackage

// File: rtl/regfile_bank.sv
// regfile_bank: one synchronous write port and one asynchronous read port over an unreset array
module regfile_bank #(
    parameter int XLEN = 32,
    parameter int REGISTER_DEPTH = 32
) (
    input  logic                              clk,
    input  logic                              we,
    input  logic [$clog2(REGISTER_DEPTH)-1:0] wa,
    input  logic [XLEN-1:0]                   wd,
    input  logic [$clog2(REGISTER_DEPTH)-1:0] ra,
    output logic [XLEN-1:0]                   rd
);
    logic [XLEN-1:0] mem [REGISTER_DEPTH];

    always_ff @(posedge clk)
        if (we) mem[wa] <= wd;

    assign rd = mem[ra];
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with post-reset clear sequencer, optional bypass and range flagging
module register_file_mp
    import kianv_regfile_pkg::*;
#(
    parameter int          XLEN           = 32,
    parameter int          REGISTER_DEPTH = 32,
    parameter int          NUM_READ_PORTS = 2,
    parameter int          BYPASS         = 0,
    parameter int          INIT_SP        = 0,
    parameter logic [31:0] STACKADDR      = 32'hffff_ffff
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           we,
    input  logic [4:0]                     A3,
    input  logic [XLEN-1:0]                wd,
    input  logic [5*NUM_READ_PORTS-1:0]    ra,
    output logic [XLEN*NUM_READ_PORTS-1:0] rd,
    output logic                           ready,
    output logic                           illegal_access
);
    localparam int AW = $clog2(REGISTER_DEPTH);
    localparam logic [5:0] DEPTH6 = 6'(REGISTER_DEPTH);

    state_t                      state;
    logic [AW-1:0]               cnt;
    logic                        clr;
    logic                        wr_legal;
    logic                        bank_we;
    logic [AW-1:0]               bank_wa;
    logic [XLEN-1:0]             bank_wd;
    logic [XLEN-1:0]             init_val;
    logic [NUM_READ_PORTS-1:0]   ra_bad;
    logic                        illegal_next;

    assign clr      = state == ST_CLEAR;
    assign wr_legal = we && A3 != 5'(REG_X0) && {1'b0, A3} < DEPTH6;
    assign init_val = (INIT_SP != 0 && cnt == AW'(REG_SP)) ? XLEN'(STACKADDR) : '0;
    assign bank_we  = clr || wr_legal;
    assign bank_wa  = clr ? cnt : A3[AW-1:0];
    assign bank_wd  = clr ? init_val : wd;

    for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_port
        logic [4:0]      ra_k;
        logic [XLEN-1:0] bank_rd;
        assign ra_k      = ra[5*k +: 5];
        assign ra_bad[k] = {1'b0, ra_k} >= DEPTH6;
        regfile_bank #(.XLEN(XLEN), .REGISTER_DEPTH(REGISTER_DEPTH)) u_bank (
            .clk (clk),
            .we  (bank_we),
            .wa  (bank_wa),
            .wd  (bank_wd),
            .ra  (ra_k[AW-1:0]),
            .rd  (bank_rd)
        );
        // write-first forwarding only for writes that will actually land
        assign rd[XLEN*k +: XLEN] = (clr || ra_k == 5'(REG_X0) || ra_bad[k]) ? '0 :
                                    (BYPASS != 0 && wr_legal && A3 == ra_k) ? wd : bank_rd;
    end

    assign illegal_next = (we && {1'b0, A3} >= DEPTH6) || |ra_bad;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state          <= ST_CLEAR;
            cnt            <= AW'(1);
            ready          <= 1'b0;
            illegal_access <= 1'b0;
        end else if (clr) begin
            illegal_access <= 1'b0;
            if (cnt == AW'(REGISTER_DEPTH - 1)) begin
                state <= ST_RUN;
                ready <= 1'b1;
            end else begin
                cnt <= cnt + AW'(1);
            end
        end else begin
            illegal_access <= illegal_next;
        end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: randomized check of rv32i (no bypass, SP preload) and rv32e (bypass) instances against a reference model
module tb_register_file_mp;
    logic        clk = 0;
    logic        resetn = 0;
    logic        we = 0;
    logic [4:0]  a3 = 0;
    logic [31:0] wd = 0;
    logic [4:0]  ra_v [3];
    logic [14:0] ra_a;
    logic [9:0]  ra_b;
    logic [95:0] rd_a;
    logic [63:0] rd_b;
    logic        ready_a, ready_b, ill_a, ill_b;

    int checks = 0;
    int failures = 0;
    int          depth  [2] = '{32, 16};
    int          nports [2] = '{3, 2};
    bit          byp    [2] = '{1'b0, 1'b1};
    logic [31:0] spv    [2] = '{32'h0000_1000, 32'h0};
    logic [31:0] mem    [2][32];
    int          edges  [2];
    bit          rdy    [2];
    bit          ill    [2];
    int          rise_a, rise_b;

    assign ra_a = {ra_v[2], ra_v[1], ra_v[0]};
    assign ra_b = {ra_v[1], ra_v[0]};

    always #5 clk = ~clk;

    register_file_mp #(.XLEN(32), .REGISTER_DEPTH(32), .NUM_READ_PORTS(3), .BYPASS(0),
                       .INIT_SP(1), .STACKADDR(32'h0000_1000)) dut_a (
        .clk(clk), .resetn(resetn), .we(we), .A3(a3), .wd(wd), .ra(ra_a), .rd(rd_a),
        .ready(ready_a), .illegal_access(ill_a));

    register_file_mp #(.XLEN(32), .REGISTER_DEPTH(16), .NUM_READ_PORTS(2), .BYPASS(1),
                       .INIT_SP(0), .STACKADDR(32'h0000_1000)) dut_b (
        .clk(clk), .resetn(resetn), .we(we), .A3(a3), .wd(wd), .ra(ra_b), .rd(rd_b),
        .ready(ready_b), .illegal_access(ill_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(int d, int k);
        int r = int'(ra_v[k]);
        if (!rdy[d] || r == 0 || r >= depth[d]) return 32'h0;
        if (byp[d] && we && int'(a3) == r) return wd;
        return mem[d][r];
    endfunction

    function automatic logic [31:0] got_rd(int d, int k);
        return d == 0 ? rd_a[32*k +: 32] : rd_b[32*k +: 32];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            edges[d] = 0;
            rdy[d]   = 0;
            ill[d]   = 0;
        end
    endtask

    task automatic settle();
        #3;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < nports[d]; k++)
                check($sformatf("rd_dut%0d_port%0d_ra%0d", d, k, ra_v[k]), got_rd(d, k), exp_rd(d, k));
    endtask

    task automatic step_edge();
        bit any;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!resetn) begin
                edges[d] = 0;
                rdy[d]   = 0;
                ill[d]   = 0;
            end else begin
                any = 0;
                for (int k = 0; k < nports[d]; k++) if (ra_v[k] >= 5'd16) any = 1;
                ill[d] = rdy[d] && depth[d] == 16 && ((we && a3 >= 5'd16) || any);
                if (rdy[d]) begin
                    if (we && a3 != 0 && int'(a3) < depth[d]) mem[d][a3] = wd;
                end else begin
                    edges[d]++;
                    if (edges[d] == depth[d] - 1) begin
                        rdy[d] = 1;
                        for (int r = 0; r < 32; r++) mem[d][r] = 32'h0;
                        mem[d][2] = spv[d];
                    end
                end
            end
        end
        #1;
        check("ready_a", {31'b0, ready_a}, {31'b0, rdy[0]});
        check("ready_b", {31'b0, ready_b}, {31'b0, rdy[1]});
        check("illegal_a", {31'b0, ill_a}, {31'b0, ill[0]});
        check("illegal_b", {31'b0, ill_b}, {31'b0, ill[1]});
    endtask

    task automatic tick();
        settle();
        step_edge();
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
        we = w; a3 = a; wd = d;
        ra_v[0] = r0; ra_v[1] = r1; ra_v[2] = r2;
    endtask

    task automatic rand_ra();
        for (int k = 0; k < 3; k++) ra_v[k] = 5'($urandom_range(0, 31));
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #1;
        check("reset_ready_a", {31'b0, ready_a}, 32'h0);
        check("reset_ready_b", {31'b0, ready_b}, 32'h0);
        check("reset_ill_a", {31'b0, ill_a}, 32'h0);
        check("reset_ill_b", {31'b0, ill_b}, 32'h0);
        repeat (3) tick();

        resetn = 1;
        for (int i = 0; i < 10; i++) begin
            rand_ra();
            tick();
        end
        resetn = 0;
        model_reset();
        #1;
        check("midclr_ready_a", {31'b0, ready_a}, 32'h0);
        check("midclr_ready_b", {31'b0, ready_b}, 32'h0);
        repeat (2) tick();

        resetn = 1;
        rise_a = 0;
        rise_b = 0;
        for (int i = 1; i <= 40; i++) begin
            rand_ra();
            if (i == 5) begin
                we = 1; a3 = 5'd3; wd = 32'haaaa;
            end else begin
                we = 0;
            end
            tick();
            if (ready_a && rise_a == 0) rise_a = i;
            if (ready_b && rise_b == 0) rise_b = i;
        end
        check("rise_edges_a", 32'(rise_a), 32'd31);
        check("rise_edges_b", 32'(rise_b), 32'd15);

        drive(0, 0, 0, 2, 3, 3);
        settle();
        check("x2_sp_a", rd_a[31:0], 32'h0000_1000);
        check("x2_b", rd_b[31:0], 32'h0);
        check("x3_clear_write_ignored", rd_a[63:32], 32'h0);
        step_edge();
        for (int r = 0; r < 32; r++) begin
            drive(0, 0, 0, 5'(r), 5'((r + 1) % 32), 5'd2);
            tick();
        end

        drive(1, 5, 32'hdead_beef, 0, 0, 0);
        tick();
        drive(0, 0, 0, 5, 5, 5);
        settle();
        check("x5_port0", rd_a[31:0], 32'hdead_beef);
        check("x5_port1", rd_a[63:32], 32'hdead_beef);
        step_edge();

        drive(1, 0, 32'h1, 0, 0, 0);
        tick();
        check("x0_write_no_flag", {31'b0, ill_b}, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        settle();
        check("x0_reads_zero", rd_a[31:0], 32'h0);
        step_edge();

        drive(1, 7, 32'h1111_1111, 0, 0, 0);
        tick();
        drive(1, 7, 32'h1234_5678, 7, 0, 0);
        settle();
        check("nobypass_old", rd_a[31:0], 32'h1111_1111);
        check("bypass_new", rd_b[31:0], 32'h1234_5678);
        step_edge();
        drive(0, 0, 0, 7, 7, 7);
        tick();

        drive(1, 20, 32'hffff_ffff, 0, 0, 0);
        tick();
        check("x20_write_flag_b", {31'b0, ill_b}, 32'h1);
        check("x20_write_noflag_a", {31'b0, ill_a}, 32'h0);
        drive(0, 0, 0, 20, 0, 0);
        settle();
        check("x20_read_b_zero", rd_b[31:0], 32'h0);
        check("x20_read_a", rd_a[31:0], 32'hffff_ffff);
        step_edge();
        check("x20_read_flag_b", {31'b0, ill_b}, 32'h1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("flag_one_cycle_b", {31'b0, ill_b}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            a3 = 5'($urandom_range(0, 31));
            wd = $urandom;
            rand_ra();
            if ($urandom_range(0, 3) == 0) ra_v[0] = a3;
            tick();
        end

        resetn = 0;
        model_reset();
        #1;
        check("midrun_ready_a", {31'b0, ready_a}, 32'h0);
        check("midrun_ill_b", {31'b0, ill_b}, 32'h0);
        resetn = 1;
        for (int i = 0; i < 35; i++) begin
            we = 1'($urandom_range(0, 1));
            a3 = 5'($urandom_range(0, 31));
            wd = $urandom;
            rand_ra();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
